mac_bank_reader: RTL and testbench

//  Readout sequencer for one 128-entry RAM-based MAC bank of the multi-tau correlator. On start it

---
 rtl/corr_pkg.sv | 20 ++
 rtl/corr_sync_fifo.sv | 55 +++++
 rtl/mac_bank_reader.sv | 207 ++++++++++++++++++++
 tb/tb_mac_bank_reader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// corr_pkg: constants and types shared by the correlator readout logic.
//   CORR_AW / CORR_DW : default bank address / accumulator widths (same as the macRam banks)
//   rd_state_e        : readout sequencer state encoding
package corr_pkg;

  localparam int CORR_AW = 7;
  localparam int CORR_DW = 32;

  typedef enum logic [2:0] {
    RD_IDLE    = 3'd0,
    RD_FREEZE  = 3'd1,
    RD_ENTER   = 3'd2,
    RD_STREAM  = 3'd3,
    RD_DRAIN   = 3'd4,
    RD_RELEASE = 3'd5,
    RD_CLEAR   = 3'd6,
    RD_DONE    = 3'd7
  } rd_state_e;

endpackage

// File: rtl/corr_sync_fifo.sv
// corr_sync_fifo: small synchronous show-ahead FIFO holding readout words.
//   clk, rst       : clock, asynchronous active-high reset
//   wr_en_i/data_i : push one word (caller guarantees space)
//   rd_en_i        : pop the head word (caller guarantees non-empty)
//   rd_data_o      : head word, valid while empty_o=0
//   count_o        : number of stored words
//   empty_o        : no words stored
module corr_sync_fifo #(
  parameter  int W     = 40,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic [PW:0]   count_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end
      if (rd_en_i) begin
        rd_ptr_q <= rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({wr_en_i, rd_en_i})
        2'b10:   count_q <= count_q + {{PW{1'b0}}, 1'b1};
        2'b01:   count_q <= count_q - {{PW{1'b0}}, 1'b1};
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign empty_o   = (count_q == {(PW+1){1'b0}});

endmodule

// File: rtl/mac_bank_reader.sv
// mac_bank_reader: readout sequencer for one RAM-based MAC bank.
// On start it freezes sampling, waits for any in-flight MAC sweep, reads every
// bank word in ascending order and streams it with its lag index over valid/ready,
// then optionally clears the bank.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : one-cycle dump request (ignored while busy)
//   busy, done        : sequence active / one-cycle completion pulse
//   freeze            : tells the sampler to suppress bank sin
//   read, rAddr, rData: bank read port (rData arrives RD_LAT cycles after rAddr)
//   clr               : one-cycle bank clear request
//   m_data/m_idx/m_last/m_valid/m_ready : output stream
module mac_bank_reader
  import corr_pkg::*;
#(
  parameter int AW         = CORR_AW,
  parameter int DW         = CORR_DW,
  parameter int RD_LAT     = 2,
  parameter int GUARD      = 2**AW + 2,
  parameter int CLR_AFTER  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          freeze,
  output logic          read,
  output logic [AW-1:0] rAddr,
  input  logic [DW-1:0] rData,
  output logic          clr,
  output logic [DW-1:0] m_data,
  output logic [AW-1:0] m_idx,
  output logic          m_last,
  output logic          m_valid,
  input  logic          m_ready
);

  localparam int FW    = DW + AW + 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = (GUARD > 2**AW + 2) ? $clog2(GUARD) + 1 : AW + 2;
  localparam logic [AW:0]   ALL_ISSUED = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] LAST_IDX   = {AW{1'b1}};

  rd_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [AW:0]    issue_q;      // next address to issue; MSB set once all are issued
  logic           issue_v_q;    // rAddr carries a fresh address this cycle
  logic [RD_LAT-1:0] pipe_v_q;
  logic [AW-1:0]  pipe_idx_q [RD_LAT];

  logic           fifo_wr_s;
  logic           fifo_rd_s;
  logic [FW-1:0]  fifo_din_s;
  logic [FW-1:0]  fifo_dout_s;
  logic [CW-1:0]  fifo_cnt_s;
  logic           fifo_empty_s;
  logic           issue_ok_s;
  logic           pipe_empty_s;
  int             occ_s;

  // Credit check: every word already issued or stored must have a FIFO slot reserved.
  // The word popped this cycle frees its slot now, which keeps 1 word/cycle throughput.
  always_comb begin
    occ_s = int'(fifo_cnt_s) + int'(issue_v_q) - int'(fifo_rd_s);
    for (int i = 0; i < RD_LAT; i++) occ_s = occ_s + int'(pipe_v_q[i]);
    issue_ok_s   = (issue_q != ALL_ISSUED) && (occ_s < FIFO_DEPTH);
    pipe_empty_s = !issue_v_q && (pipe_v_q == {RD_LAT{1'b0}});
  end

  assign fifo_wr_s  = pipe_v_q[RD_LAT-1];
  assign fifo_din_s = {(pipe_idx_q[RD_LAT-1] == LAST_IDX), pipe_idx_q[RD_LAT-1], rData};
  assign fifo_rd_s  = !fifo_empty_s && (!m_valid || m_ready);

  // Sequencer FSM with registered control outputs and address issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RD_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      freeze    <= 1'b0;
      read      <= 1'b0;
      clr       <= 1'b0;
      rAddr     <= '0;
      cnt_q     <= '0;
      issue_q   <= '0;
      issue_v_q <= 1'b0;
    end else begin
      done      <= 1'b0;
      clr       <= 1'b0;
      issue_v_q <= 1'b0;
      case (state_q)
        RD_IDLE: begin
          if (start) begin
            state_q <= RD_FREEZE;
            busy    <= 1'b1;
            freeze  <= 1'b1;
            cnt_q   <= CNT_W'(GUARD - 1);
            issue_q <= '0;
          end
        end
        RD_FREEZE: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_q <= RD_ENTER;
            read    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        RD_ENTER, RD_STREAM: begin
          // Address for the next cycle is registered here, so address 0 appears
          // on rAddr in the first STREAM cycle, when the bank is in read state.
          if (issue_ok_s) begin
            issue_v_q <= 1'b1;
            rAddr     <= issue_q[AW-1:0];
            issue_q   <= issue_q + {{AW{1'b0}}, 1'b1};
          end
          if (state_q == RD_ENTER) begin
            state_q <= RD_STREAM;
          end else if (issue_q == ALL_ISSUED) begin
            state_q <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (fifo_empty_s && pipe_empty_s && !m_valid) begin
            state_q <= RD_RELEASE;
            read    <= 1'b0;
          end
        end
        RD_RELEASE: begin
          if (CLR_AFTER != 0) begin
            state_q <= RD_CLEAR;
            clr     <= 1'b1;
            cnt_q   <= CNT_W'(2**AW + 1);
          end else begin
            state_q <= RD_DONE;
            done    <= 1'b1;
          end
        end
        RD_CLEAR: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_q <= RD_DONE;
            done    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        RD_DONE: begin
          state_q <= RD_IDLE;
          busy    <= 1'b0;
          freeze  <= 1'b0;
        end
        default: begin
          state_q <= RD_IDLE;
          busy    <= 1'b0;
          freeze  <= 1'b0;
          read    <= 1'b0;
        end
      endcase
    end
  end

  // Read-latency pipe: marks which cycle's rData belongs to an issued address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_idx_q[i] <= '0;
    end else begin
      pipe_v_q[0]   <= issue_v_q;
      pipe_idx_q[0] <= rAddr;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v_q[i]   <= pipe_v_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

  corr_sync_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fifo_wr_s),
    .wr_data_i (fifo_din_s),
    .rd_en_i   (fifo_rd_s),
    .rd_data_o (fifo_dout_s),
    .count_o   (fifo_cnt_s),
    .empty_o   (fifo_empty_s)
  );

  // Registered stream stage: holds its word until accepted, reloads from the FIFO head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_idx   <= '0;
      m_last  <= 1'b0;
    end else if (fifo_rd_s) begin
      m_valid                  <= 1'b1;
      {m_last, m_idx, m_data}  <= fifo_dout_s;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_bank_reader.sv
module tb_mac_bank_reader;

  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int N     = 2**AW;
  localparam int GUARD = N + 2;

  logic          clk = 1'b0;
  logic          rst, start, sin;
  logic          busy, done, freeze, read, clr;
  logic [AW-1:0] rAddr, m_idx;
  logic [DW-1:0] rData, m_data;
  logic          m_last, m_valid, m_ready;

  always #5 clk = ~clk;

  mac_bank_reader dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .freeze(freeze),
    .read(read), .rAddr(rAddr), .rData(rData), .clr(clr), .m_data(m_data),
    .m_idx(m_idx), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
  );

  // ---------------- behavioural macRam bank: sin > clr > read, 2-cycle read ----------------
  logic [DW-1:0] ram [N];
  logic [DW-1:0] load_val [N];
  logic          load_req = 1'b0;
  logic          bank_rd = 1'b0, sweep_on = 1'b0, sweep_clr = 1'b0;
  int            sweep_cnt = 0;
  logic [DW-1:0] pipe1;
  int            conflicts = 0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) ram[i] <= load_val[i];
      bank_rd <= 1'b0;
    end else if (sweep_on) begin
      if (sweep_cnt < N) ram[sweep_cnt] <= sweep_clr ? '0 : ram[sweep_cnt] + DW'(sweep_cnt + 1);
      if (sweep_cnt == N) sweep_on <= 1'b0;
      sweep_cnt <= sweep_cnt + 1;
      bank_rd   <= 1'b0;
      if (read) conflicts <= conflicts + 1;
    end else if (sin) begin
      sweep_on <= 1'b1; sweep_clr <= 1'b0; sweep_cnt <= 0; bank_rd <= 1'b0;
    end else if (clr) begin
      sweep_on <= 1'b1; sweep_clr <= 1'b1; sweep_cnt <= 0; bank_rd <= 1'b0;
    end else begin
      bank_rd <= read;
    end
    pipe1 <= bank_rd ? ram[rAddr] : 32'hDEAD_BEEF;
    rData <= pipe1;
  end

  // ---------------- monitor ----------------
  logic [DW+AW:0] got_q [$];
  int   cyc = 0;
  int   done_cnt = 0, clr_cnt = 0, stab_err = 0, frz_err = 0, wide_err = 0;
  int   t_busy = 0, t_rd_rise = 0, t_rd_fall = 0, t_clr = 0, t_done = 0;
  logic prev_stall = 1'b0, prev_busy = 1'b0, prev_read = 1'b0, prev_done = 1'b0, prev_clr = 1'b0;
  logic [DW+AW:0] prev_word = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      prev_stall <= 1'b0; prev_busy <= 1'b0; prev_read <= 1'b0;
      prev_done <= 1'b0; prev_clr <= 1'b0;
    end else begin
      if (m_valid && m_ready) got_q.push_back({m_last, m_idx, m_data});
      if (prev_stall && (!m_valid || ({m_last, m_idx, m_data} !== prev_word)))
        stab_err <= stab_err + 1;
      if (busy && !freeze) frz_err <= frz_err + 1;
      if ((done && prev_done) || (clr && prev_clr)) wide_err <= wide_err + 1;
      if (busy && !prev_busy) t_busy <= cyc;
      if (read && !prev_read) t_rd_rise <= cyc;
      if (!read && prev_read) t_rd_fall <= cyc;
      if (clr) begin clr_cnt <= clr_cnt + 1; t_clr <= cyc; end
      if (done) begin done_cnt <= done_cnt + 1; t_done <= cyc; end
      prev_stall <= m_valid && !m_ready;
      prev_word  <= {m_last, m_idx, m_data};
      prev_busy  <= busy; prev_read <= read; prev_done <= done; prev_clr <= clr;
    end
  end

  // ---------------- ready generator ----------------
  int rmode = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rmode)
        1:       m_ready = ((cyc % 3) == 0);
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0, n_fail = 0;
  logic [DW-1:0] exp_v [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // kind 0: ram[i]=3*i, kind 1: random contents
  task automatic preload(input int kind);
    for (int i = 0; i < N; i++) begin
      load_val[i] = (kind == 0) ? DW'(3 * i) : $urandom;
      exp_v[i]    = load_val[i];
    end
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic do_dump(input string tag, input int mode, input bit pulse_sin, input bit abuse);
    int base, d0, c0, rd_seen;
    bit fin;
    base = got_q.size(); d0 = done_cnt; c0 = clr_cnt;
    rmode = mode;
    @(negedge clk);
    if (pulse_sin) begin sin = 1'b1; @(negedge clk); sin = 1'b0; end
    start = 1'b1; @(negedge clk); start = 1'b0;
    fin = 1'b0; rd_seen = 0;
    for (int k = 0; k < 4000 && !fin; k++) begin
      if (read) rd_seen++;
      start = abuse && ((rd_seen == 20) || done);
      if (done) fin = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " finished"}, 64'(fin), 64'd1);
    repeat (5) @(negedge clk);
    check({tag, " idle after"}, 64'(busy), 64'd0);
    check({tag, " done pulses"}, 64'(done_cnt - d0), 64'd1);
    check({tag, " clr pulses"}, 64'(clr_cnt - c0), 64'd1);
    check({tag, " guard"}, 64'(t_rd_rise - t_busy), 64'(GUARD));
    check({tag, " clr after read"}, 64'(t_clr - t_rd_fall), 64'd1);
    check({tag, " clear wait"}, 64'(t_done - t_clr), 64'(N + 2));
    check({tag, " word count"}, 64'(got_q.size() - base), 64'(N));
    for (int i = 0; i < N; i++) begin
      if (base + i < got_q.size())
        check({tag, " word"}, 64'(got_q[base + i]), 64'({(i == N - 1), AW'(i), exp_v[i]}));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", 64'({busy, done, freeze, read, clr, m_valid, m_last, rAddr, m_idx}), 64'd0);
    check("reset m_data", 64'(m_data), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    preload(0);
    do_dump("basic", 0, 1'b0, 1'b0);

    preload(0);
    do_dump("stall1of3", 1, 1'b0, 1'b0);

    for (int i = 0; i < N; i++) exp_v[i] = '0;
    do_dump("cleared", 0, 1'b0, 1'b0);

    preload(0);
    for (int i = 0; i < N; i++) exp_v[i] = DW'(3 * i + i + 1);
    do_dump("after_mac", 2, 1'b1, 1'b0);

    preload(1);
    do_dump("start_abuse", 2, 1'b0, 1'b1);

    // reset in the middle of a dump
    preload(0);
    rmode = 0;
    begin
      int base;
      bit hit;
      base = got_q.size(); hit = 1'b0;
      @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
      for (int k = 0; k < 2000 && !hit; k++) begin
        if (got_q.size() >= base + 51) hit = 1'b1;
        else @(negedge clk);
      end
      check("reached word 50", 64'(hit), 64'd1);
      rst = 1'b1;
      #1;
      check("async reset outputs", 64'({busy, done, freeze, read, clr, m_valid, m_last, rAddr, m_idx}), 64'd0);
      check("async reset m_data", 64'(m_data), 64'd0);
      @(negedge clk); rst = 1'b0;
    end
    preload(0);
    do_dump("after_reset", 0, 1'b0, 1'b0);

    check("stream stable while stalled", 64'(stab_err), 64'd0);
    check("freeze while busy", 64'(frz_err), 64'd0);
    check("single-cycle pulses", 64'(wide_err), 64'd0);
    check("read during bank sweep", 64'(conflicts), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
